// File: rtl/fft_mem_reader_if.sv
// Bus bundle between the FFT frame reader, its memory group and the downstream stream sink.
// The master side generates read addresses and drives the output beat stream.
interface fft_mem_reader_if #(
  parameter int SIZE_GROUP  = 8,
  parameter int DWIDTH_BRAM = 64,
  parameter int AWIDTH_BRAM = 12
);
  logic [AWIDTH_BRAM-1:0]            addrc;
  logic [SIZE_GROUP*DWIDTH_BRAM-1:0] mem_dout;
  logic [SIZE_GROUP*DWIDTH_BRAM-1:0] m_tdata;
  logic                              m_tvalid;
  logic                              m_tready;
  logic                              m_tlast;

  modport master (
    output addrc,
    input  mem_dout,
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  addrc,
    output mem_dout,
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/fft_mem_reader.sv
// Read-side controller for the FFT ping-pong memory group: scans one LENGTH x LENGTH
// frame in row or column order and streams the returned lane data with backpressure.
module fft_mem_reader #(
  parameter int LENGTH      = 64,
  parameter int SIZE_GROUP  = 8,
  parameter int DWIDTH_BRAM = 64,
  parameter int AWIDTH_BRAM = 12,
  parameter int RD_LATENCY  = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             transpose,
  output logic             busy,
  output logic             done,
  fft_mem_reader_if.master bus
);
  localparam int DW = SIZE_GROUP * DWIDTH_BRAM;
  localparam int LW = $clog2(LENGTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] LAST_RC  = LW'(LENGTH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic                   tr_r;
  logic                   busy_r;
  logic                   done_r;
  logic [LW-1:0]          row_r;
  logic [LW-1:0]          col_r;
  logic [AWIDTH_BRAM-1:0] addrc_r;
  logic [RD_LATENCY-1:0]  vpipe_r;
  logic [RD_LATENCY-1:0]  lpipe_r;
  logic [CW-1:0]          inflight_r;
  logic [CW-1:0]          st_cnt_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [DW-1:0]          fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last_r;
  logic [DW-1:0]          out_data_r;
  logic                   out_valid_r;
  logic                   out_last_r;

  logic [CW:0]            occupied_s;
  logic                   issue_s;
  logic                   last_idx_s;
  logic [AWIDTH_BRAM-1:0] addr_s;
  logic                   capture_s;
  logic                   cap_last_s;
  logic                   pop_s;
  logic                   load_s;
  logic                   drained_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  // Per-cycle issue, capture and output-stage decisions; the output register counts
  // toward occupancy so reads in flight can never exceed the space left to hold them.
  always_comb begin
    occupied_s = {1'b0, st_cnt_r} + {1'b0, inflight_r} + {{CW{1'b0}}, out_valid_r};
    issue_s    = (state_r == RUN) && (occupied_s < DEPTH_C);
    last_idx_s = (row_r == LAST_RC) && (col_r == LAST_RC);
    addr_s     = tr_r ? AWIDTH_BRAM'({col_r, row_r}) : AWIDTH_BRAM'({row_r, col_r});
    capture_s  = vpipe_r[RD_LATENCY-1];
    cap_last_s = lpipe_r[RD_LATENCY-1];
    pop_s      = out_valid_r && bus.m_tready;
    load_s     = (st_cnt_r != {CW{1'b0}}) && (!out_valid_r || bus.m_tready);
    drained_s  = (inflight_r == {CW{1'b0}}) && (st_cnt_r == {CW{1'b0}}) && !out_valid_r;
  end

  // Frame control: scan counters, read address and status outputs.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      tr_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      row_r   <= {LW{1'b0}};
      col_r   <= {LW{1'b0}};
      addrc_r <= {AWIDTH_BRAM{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            tr_r    <= transpose;
            busy_r  <= 1'b1;
            row_r   <= {LW{1'b0}};
            col_r   <= {LW{1'b0}};
          end
        end
        RUN: begin
          if (issue_s) begin
            addrc_r <= addr_s;
            col_r   <= col_r + LW'(1'b1);
            if (col_r == LAST_RC) begin
              row_r <= row_r + LW'(1'b1);
            end
            if (last_idx_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Valid pipe matching the memory read latency, with the end-of-frame tag riding along.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      vpipe_r    <= {RD_LATENCY{1'b0}};
      lpipe_r    <= {RD_LATENCY{1'b0}};
      inflight_r <= {CW{1'b0}};
    end else begin
      vpipe_r    <= {vpipe_r[RD_LATENCY-2:0], issue_s};
      lpipe_r    <= {lpipe_r[RD_LATENCY-2:0], issue_s && last_idx_s};
      inflight_r <= inflight_r + CW'(issue_s) - CW'(capture_s);
    end
  end

  // Skid storage array; slots are only read after being written, so no reset is needed.
  always_ff @(posedge sclk) begin
    if (capture_s) begin
      fifo_data_r[wr_ptr_r] <= bus.mem_dout;
    end
  end

  // Storage pointers, fill count and the registered first-word output stage.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      st_cnt_r    <= {CW{1'b0}};
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      if (capture_s) begin
        fifo_last_r[wr_ptr_r] <= cap_last_s;
        wr_ptr_r              <= ptr_next(wr_ptr_r);
      end
      if (load_s) begin
        out_data_r  <= fifo_data_r[rd_ptr_r];
        out_last_r  <= fifo_last_r[rd_ptr_r];
        out_valid_r <= 1'b1;
        rd_ptr_r    <= ptr_next(rd_ptr_r);
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
      st_cnt_r <= st_cnt_r + CW'(capture_s) - CW'(load_s);
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign bus.addrc    = addrc_r;
  assign bus.m_tdata  = out_data_r;
  assign bus.m_tvalid = out_valid_r;
  assign bus.m_tlast  = out_last_r;
endmodule

// File: tb/tb_fft_mem_reader.sv
// Directed bench for fft_mem_reader on a 4x4 frame: timing, scan order, backpressure,
// random ready, start filtering and mid-frame reset.
`timescale 1ns/1ps
module tb_fft_mem_reader;
  localparam int L   = 4;
  localparam int N   = L * L;
  localparam int SG  = 8;
  localparam int DWB = 64;
  localparam int AW  = 4;
  localparam int RL  = 4;
  localparam int FD  = 8;
  localparam int DW  = SG * DWB;

  logic sclk = 1'b0;
  logic rst;
  logic start;
  logic transpose;
  logic busy;
  logic done;

  fft_mem_reader_if #(.SIZE_GROUP(SG), .DWIDTH_BRAM(DWB), .AWIDTH_BRAM(AW)) bus ();

  fft_mem_reader #(
    .LENGTH(L), .SIZE_GROUP(SG), .DWIDTH_BRAM(DWB), .AWIDTH_BRAM(AW),
    .RD_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .sclk(sclk), .rst(rst), .start(start), .transpose(transpose),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 sclk = ~sclk;

  // Memory group model: data sampled by the reader RL edges after addrc was loaded.
  logic [AW-1:0] a1, a2, a3;
  always @(posedge sclk) begin
    a1 <= bus.addrc;
    a2 <= a1;
    a3 <= a2;
  end

  function automatic logic [DW-1:0] beat_of(input int a);
    logic [DW-1:0] b;
    b = {DW{1'b0}};
    for (int l = 0; l < SG; l++) b[l*DWB +: DWB] = {32'(l), 32'(a)};
    return b;
  endfunction

  function automatic int exp_addr(input bit tr, input int k);
    return tr ? (k % L) * L + (k / L) : k;
  endfunction

  assign bus.mem_dout = beat_of(int'(a3));

  int checks = 0;
  int failures = 0;
  int e;
  int got;
  bit rnd_ready = 1'b0;
  logic [DW-1:0] dq[$];
  logic          lq[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
      dq.push_back(bus.m_tdata);
      lq.push_back(bus.m_tlast);
    end
    @(negedge sclk);
    e++;
  endtask

  task automatic start_frame(input bit tr);
    dq.delete();
    lq.delete();
    start = 1'b1;
    transpose = tr;
    e = -1;
    cyc();
    start = 1'b0;
    transpose = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    got = 0;
    for (int i = 0; i < 600 && got == 0; i++) begin
      if (rnd_ready) bus.m_tready = 1'($urandom_range(0, 1));
      else bus.m_tready = 1'b1;
      cyc();
      if (done === 1'b1) got = 1;
    end
    chk({tag, " done"}, got, 1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
  endtask

  task automatic check_frame(input string tag, input bit tr);
    int ntl;
    ntl = 0;
    chk({tag, " beats"}, dq.size(), N);
    for (int k = 0; k < N && k < dq.size(); k++) begin
      chk($sformatf("%s beat%0d", tag, k), dq[k], beat_of(exp_addr(tr, k)));
      if (lq[k] === 1'b1) ntl++;
    end
    chk({tag, " tlast_count"}, ntl, 1);
    if (lq.size() == N) chk({tag, " tlast_pos"}, lq[N-1], 1'b1);
  endtask

  task automatic idle();
    bus.m_tready = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    transpose = 1'b0;
    bus.m_tready = 1'b1;
    repeat (2) @(negedge sclk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst addrc", bus.addrc, 4'd0);
    chk("rst tvalid", bus.m_tvalid, 1'b0);
    chk("rst tlast", bus.m_tlast, 1'b0);
    chk("rst tdata", bus.m_tdata, {DW{1'b0}});
    rst = 1'b0;
    idle();
    idle();

    // Row scan, full throughput: exact latency and sequencing.
    start_frame(1'b0);
    chk("t1 busy", busy, 1'b1);
    cyc();
    chk("t1 addr_e1", bus.addrc, 4'd0);
    cyc();
    chk("t1 addr_e2", bus.addrc, 4'd1);
    cyc();
    chk("t1 addr_e3", bus.addrc, 4'd2);
    cyc();
    cyc();
    chk("t1 tvalid_e5", bus.m_tvalid, 1'b0);
    cyc();
    chk("t1 tvalid_e6", bus.m_tvalid, 1'b1);
    chk("t1 tdata_e6", bus.m_tdata, beat_of(0));
    for (int i = 0; i < 10; i++) cyc();
    chk("t1 addr_e16", bus.addrc, 4'd15);
    wait_done("t1");
    chk("t1 done_edge", e, 23);
    check_frame("t1", 1'b0);
    idle();
    chk("t1 done_pulse", done, 1'b0);

    // Column scan with lane tags.
    start_frame(1'b1);
    wait_done("t2");
    check_frame("t2", 1'b1);
    idle();

    // Stalled sink: credit limits reads to the buffer depth, output held.
    bus.m_tready = 1'b0;
    start_frame(1'b0);
    for (int i = 0; i < 12; i++) cyc();
    chk("t3 addr_frozen12", bus.addrc, 4'd7);
    chk("t3 tvalid12", bus.m_tvalid, 1'b1);
    chk("t3 tdata12", bus.m_tdata, beat_of(0));
    for (int i = 0; i < 8; i++) cyc();
    chk("t3 addr_frozen20", bus.addrc, 4'd7);
    chk("t3 tdata20", bus.m_tdata, beat_of(0));
    chk("t3 busy20", busy, 1'b1);
    wait_done("t3");
    check_frame("t3", 1'b0);
    idle();

    // Random backpressure in both scan orders.
    rnd_ready = 1'b1;
    start_frame(1'b0);
    wait_done("t4r");
    check_frame("t4r", 1'b0);
    idle();
    start_frame(1'b1);
    wait_done("t4c");
    check_frame("t4c", 1'b1);
    idle();
    rnd_ready = 1'b0;

    // Start ignored mid-frame and in the done cycle, accepted one cycle later.
    start_frame(1'b0);
    for (int i = 0; i < 10; i++) cyc();
    start = 1'b1;
    transpose = 1'b1;
    cyc();
    start = 1'b0;
    transpose = 1'b0;
    chk("t5 busy_mid", busy, 1'b1);
    wait_done("t5a");
    check_frame("t5a", 1'b0);
    dq.delete();
    lq.delete();
    start = 1'b1;
    transpose = 1'b1;
    cyc();
    chk("t5 start_in_done", busy, 1'b0);
    cyc();
    start = 1'b0;
    transpose = 1'b0;
    chk("t5 start_after", busy, 1'b1);
    wait_done("t5b");
    check_frame("t5b", 1'b1);
    idle();

    // Asynchronous reset mid-frame, then a clean restart.
    start_frame(1'b0);
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      cyc();
      if (dq.size() >= 5) got = 1;
    end
    chk("t6 reach_beat5", got, 1);
    rst = 1'b1;
    #1;
    chk("t6 tvalid", bus.m_tvalid, 1'b0);
    chk("t6 busy", busy, 1'b0);
    chk("t6 addrc", bus.addrc, 4'd0);
    chk("t6 tdata", bus.m_tdata, {DW{1'b0}});
    chk("t6 tlast", bus.m_tlast, 1'b0);
    cyc();
    rst = 1'b0;
    idle();
    start_frame(1'b0);
    wait_done("t6b");
    check_frame("t6b", 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
